pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width in bits (min 8).
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, PC loaded on trap or misalign.
REQ-004 SHALL have parameter CNT_W, default 16, retire counter width.
REQ-005 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hold PC this cycle
- branch_taken_i  in  1  load branch_target_i
- branch_target_i  in  XLEN  branch destination
- jump_i  in  1  load jump_target_i
- jump_target_i  in  XLEN  jump destination
- trap_i  in  1  load TRAP_VECTOR
- halt_i  in  1  request halt
- resume_i  in  1  leave halt
- pc_o  out  XLEN  current PC
- pc_plus4_o  out  XLEN  pc_o+4, combinational
- fetch_valid_o  out  1  pc_o is a valid fetch address
- halted_o  out  1  FSM in HALT
- misalign_o  out  1  one-cycle misaligned-target pulse
- retire_count_o  out  CNT_W  count of PC advances

Function
REQ-006 SHALL implement FSM states BOOT, RUN, HALT; BOOT entered on reset.
REQ-007 BOOT SHALL last exactly one cycle after rst_n deasserts, pc_o=RESET_VECTOR, fetch_valid_o=0, then go to RUN ignoring all inputs.
REQ-008 In RUN, next PC priority SHALL be: trap_i > stall_i > jump_i > branch_taken_i > pc_o+4.
REQ-009 trap_i in RUN SHALL load TRAP_VECTOR even when stall_i=1.
REQ-010 stall_i=1 without trap_i SHALL hold pc_o and retire_count_o; jump_i/branch_taken_i asserted that cycle SHALL be discarded.
REQ-011 pc_o+4 and pc_plus4_o SHALL wrap modulo 2^XLEN (all-ones-minus-3 -> 0).
REQ-012 PC update latency SHALL be one cycle: inputs sampled at edge N appear on pc_o after edge N.
REQ-013 halt_i in RUN (no trap_i) SHALL go to HALT, holding pc_o; trap_i with halt_i SHALL load TRAP_VECTOR and stay RUN.
REQ-014 In HALT: fetch_valid_o=0, halted_o=1, pc_o held; resume_i -> RUN with pc_o unchanged; trap_i -> RUN with pc_o=TRAP_VECTOR; other inputs ignored.
REQ-015 fetch_valid_o SHALL be 1 in RUN only.
REQ-016 retire_count_o SHALL increment by 1, wrapping at 2^CNT_W, on every RUN cycle where pc_o changes or advances (sequential, branch, jump, trap); not on stall or HALT.

Reset
REQ-017 rst_n low SHALL immediately, asynchronously force: state=BOOT, pc_o=RESET_VECTOR, retire_count_o=0, misalign_o=0, halted_o=0, fetch_valid_o=0.
REQ-018 Reset asserted mid-operation (any state, any pending redirect) SHALL discard all pending requests.

Configuration
REQ-019 Macro PC_MISALIGN_TRAP_EN defined: a selected jump/branch target with bits [1:0]!=0 SHALL load TRAP_VECTOR instead, pulse misalign_o for one cycle, and count as an advance.
REQ-020 PC_MISALIGN_TRAP_EN undefined: target bits [1:0] SHALL be forced to 0 before loading; misalign_o SHALL be constant 0.

Verification
REQ-021 Reset release -> pc_o=0, fetch_valid_o=0 one cycle, then 0,4,8,C; retire_count_o 0,1,2,3.
REQ-022 At pc_o=0x10 assert jump_i (0x80) and branch_taken_i (0x40) together -> next pc_o=0x80; stall_i with jump_i at 0x80 -> pc_o stays 0x80, count unchanged.
REQ-023 XLEN=8, pc_o=0xFC sequential -> pc_o=0x00; CNT_W=2 after 4 advances -> retire_count_o=0.
REQ-024 halt_i at pc_o=0x20 -> halted_o=1, pc_o=0x20 for 5 cycles; resume_i -> RUN, next pc_o=0x24; trap_i with halt_i -> pc_o=0x100, halted_o=0.
REQ-025 Jump to 0x82 -> with macro: pc_o=0x100, misalign_o=1 one cycle; without: pc_o=0x80, misalign_o=0.
REQ-026 rst_n low mid-stall at pc_o=0x44 between edges -> pc_o=0 and retire_count_o=0 before next clk edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, redirect priority, and a retire counter.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned jump/branch targets; otherwise their low bits are cleared.
module pc_sequencer #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [XLEN-1:0]  branch_target_i,
    input  logic             jump_i,
    input  logic [XLEN-1:0]  jump_target_i,
    input  logic             trap_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic             fetch_valid_o,
    output logic             halted_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] retire_count_o
);

    // state | meaning
    // BOOT  | one cycle after reset, pc = RESET_VECTOR, no fetch
    // RUN   | fetching; pc redirected or advanced each cycle
    // HALT  | pc frozen until resume_i or trap_i
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [XLEN-1:0] RST_PC  = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VECTOR);

    state_t           state, state_nxt;
    logic [XLEN-1:0]  pc, pc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0]  tgt;
    logic             tgt_sel;
    logic             mis_nxt;

    assign pc_plus4_o     = pc + XLEN'(4);
    assign pc_o           = pc;
    assign retire_count_o = cnt;
    assign fetch_valid_o  = (state == RUN);
    assign halted_o       = (state == HALT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        mis_nxt   = 1'b0;
        tgt       = jump_i ? jump_target_i : branch_target_i;
        tgt_sel   = jump_i | branch_taken_i;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (trap_i) begin
                    pc_nxt  = TRAP_PC;
                    cnt_nxt = cnt + CNT_W'(1);
                end else if (halt_i) begin
                    state_nxt = HALT;
                end else if (stall_i) begin
                    pc_nxt = pc;
                end else if (tgt_sel) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (tgt[1:0] != 2'b00) begin
                        pc_nxt  = TRAP_PC;
                        mis_nxt = 1'b1;
                    end else begin
                        pc_nxt = tgt;
                    end
`else
                    pc_nxt = tgt & ~XLEN'(3);
`endif
                    cnt_nxt = cnt + CNT_W'(1);
                end else begin
                    pc_nxt  = pc_plus4_o;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HALT: begin
                if (trap_i) begin
                    state_nxt = RUN;
                    pc_nxt    = TRAP_PC;
                end else if (resume_i) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RST_PC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic mis;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis <= 1'b0;
        else        mis <= mis_nxt;
    end
    assign misalign_o = mis;
`else
    logic mis_unused;
    assign mis_unused = mis_nxt;
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset run-up, a vector table of redirects/halts, XLEN=8 wrap and mid-cycle reset.
module tb_pc_sequencer;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, br, jmp, trap, halt, resume;
    logic [31:0] br_t, jmp_t;
    logic [31:0] pc, pc4;
    logic        fv, hlt, mis;
    logic [15:0] cnt;
    logic [7:0]  s_pc, s_pc4;
    logic        s_fv, s_hlt, s_mis;
    logic [1:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(br),
        .branch_target_i(br_t), .jump_i(jmp), .jump_target_i(jmp_t),
        .trap_i(trap), .halt_i(halt), .resume_i(resume),
        .pc_o(pc), .pc_plus4_o(pc4), .fetch_valid_o(fv), .halted_o(hlt),
        .misalign_o(mis), .retire_count_o(cnt)
    );

    pc_sequencer #(.XLEN(8), .RESET_VECTOR(32'h0000_00F0), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .branch_taken_i(1'b0),
        .branch_target_i(8'h00), .jump_i(1'b0), .jump_target_i(8'h00),
        .trap_i(1'b0), .halt_i(1'b0), .resume_i(1'b0),
        .pc_o(s_pc), .pc_plus4_o(s_pc4), .fetch_valid_o(s_fv), .halted_o(s_hlt),
        .misalign_o(s_mis), .retire_count_o(s_cnt)
    );

    typedef struct {
        logic        st, b, j, t, h, r;
        logic [31:0] bt, jt;
        logic [31:0] e_pc;
        logic [15:0] e_cnt;
        logic        e_fv, e_h, e_m;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(logic st, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                                logic t, logic h, logic r, logic [31:0] epc, logic [15:0] ecnt,
                                logic efv, logic eh, logic em);
        vec_t v;
        v.st = st; v.b = b; v.bt = bt; v.j = j; v.jt = jt; v.t = t; v.h = h; v.r = r;
        v.e_pc = epc; v.e_cnt = ecnt; v.e_fv = efv; v.e_h = eh; v.e_m = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; br = 0; jmp = 0; trap = 0; halt = 0; resume = 0;
        br_t = '0; jmp_t = '0;
    endtask

    logic [7:0] s_exp_pc [5] = '{8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'h00};
    logic [1:0] s_exp_cnt[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        //            st b  bt     j  jt     t  h  r  pc      cnt fv h m
        vecs[0]  = mk(0, 1, 'h40, 1, 'h80,  0, 0, 0, 'h80,  5,  1, 0, 0);
        vecs[1]  = mk(1, 0, 'h0,  1, 'h84,  0, 0, 0, 'h80,  5,  1, 0, 0);
        vecs[2]  = mk(0, 1, 'h40, 0, 'h0,   0, 0, 0, 'h40,  6,  1, 0, 0);
        vecs[3]  = mk(1, 0, 'h0,  0, 'h0,   1, 0, 0, 'h100, 7,  1, 0, 0);
        vecs[4]  = mk(0, 0, 'h0,  0, 'h0,   0, 0, 0, 'h104, 8,  1, 0, 0);
        vecs[5]  = mk(0, 0, 'h0,  1, 'h1C,  0, 0, 0, 'h1C,  9,  1, 0, 0);
        vecs[6]  = mk(0, 0, 'h0,  0, 'h0,   0, 0, 0, 'h20,  10, 1, 0, 0);
        vecs[7]  = mk(0, 0, 'h0,  0, 'h0,   0, 1, 0, 'h20,  10, 0, 1, 0);
        vecs[8]  = mk(0, 0, 'h0,  0, 'h0,   0, 0, 0, 'h20,  10, 0, 1, 0);
        vecs[9]  = mk(0, 0, 'h0,  1, 'h80,  0, 0, 0, 'h20,  10, 0, 1, 0);
        vecs[10] = mk(1, 1, 'h40, 0, 'h0,   0, 0, 0, 'h20,  10, 0, 1, 0);
        vecs[11] = mk(0, 0, 'h0,  0, 'h0,   0, 1, 0, 'h20,  10, 0, 1, 0);
        vecs[12] = mk(0, 0, 'h0,  0, 'h0,   0, 0, 0, 'h20,  10, 0, 1, 0);
        vecs[13] = mk(0, 0, 'h0,  0, 'h0,   0, 0, 1, 'h20,  10, 1, 0, 0);
        vecs[14] = mk(0, 0, 'h0,  0, 'h0,   0, 0, 0, 'h24,  11, 1, 0, 0);
        vecs[15] = mk(0, 0, 'h0,  0, 'h0,   0, 1, 0, 'h24,  11, 0, 1, 0);
        vecs[16] = mk(0, 0, 'h0,  0, 'h0,   1, 0, 1, 'h100, 11, 1, 0, 0);
        vecs[17] = mk(0, 0, 'h0,  0, 'h0,   1, 1, 0, 'h100, 12, 1, 0, 0);
        vecs[18] = mk(0, 0, 'h0,  1, 'h82,  0, 0, 0, MIS_EN ? 'h100 : 'h80, 13, 1, 0, MIS_EN);
        vecs[19] = mk(0, 0, 'h0,  0, 'h0,   0, 0, 0, MIS_EN ? 'h104 : 'h84, 14, 1, 0, 0);
        vecs[20] = mk(0, 1, 'h43, 0, 'h0,   0, 0, 0, MIS_EN ? 'h100 : 'h40, 15, 1, 0, MIS_EN);
        vecs[21] = mk(0, 0, 'h0,  1, 'h80,  1, 0, 0, 'h100, 16, 1, 0, 0);
        vecs[22] = mk(1, 0, 'h0,  0, 'h0,   0, 0, 0, 'h100, 16, 1, 0, 0);
        vecs[23] = mk(0, 0, 'h0,  1, 'h44,  0, 0, 0, 'h44,  17, 1, 0, 0);
        vecs[24] = mk(1, 0, 'h0,  1, 'h48,  0, 0, 0, 'h44,  17, 1, 0, 0);

        idle_inputs();
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_cnt", {16'h0, cnt}, 32'h0);
        chk("rst_fv", {31'h0, fv}, 32'h0);
        chk("rst_halted", {31'h0, hlt}, 32'h0);
        chk("rst_mis", {31'h0, mis}, 32'h0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("boot_fv", {31'h0, fv}, 32'h0);
        chk("boot_pc", pc, 32'h0);
        chk("small_boot_pc", {24'h0, s_pc}, 32'h0000_00F0);

        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("runup%0d_pc", k), pc, 32'(4 * k));
            chk($sformatf("runup%0d_cnt", k), {16'h0, cnt}, 32'(k));
            chk($sformatf("runup%0d_fv", k), {31'h0, fv}, 32'h1);
            chk($sformatf("small%0d_pc", k), {24'h0, s_pc}, {24'h0, s_exp_pc[k]});
            chk($sformatf("small%0d_pc4", k), {24'h0, s_pc4}, {24'h0, 8'(s_exp_pc[k] + 8'h04)});
            chk($sformatf("small%0d_cnt", k), {30'h0, s_cnt}, {30'h0, s_exp_cnt[k]});
        end

        for (int i = 0; i < 25; i++) begin
            stall = vecs[i].st; br = vecs[i].b; br_t = vecs[i].bt;
            jmp = vecs[i].j; jmp_t = vecs[i].jt; trap = vecs[i].t;
            halt = vecs[i].h; resume = vecs[i].r;
            @(posedge clk); #1;
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_pc4", i), pc4, vecs[i].e_pc + 32'h4);
            chk($sformatf("v%0d_cnt", i), {16'h0, cnt}, {16'h0, vecs[i].e_cnt});
            chk($sformatf("v%0d_fv", i), {31'h0, fv}, {31'h0, vecs[i].e_fv});
            chk($sformatf("v%0d_halted", i), {31'h0, hlt}, {31'h0, vecs[i].e_h});
            chk($sformatf("v%0d_mis", i), {31'h0, mis}, {31'h0, vecs[i].e_m});
        end

        // Still stalling at 0x44 with a jump pending; pull reset between edges.
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_cnt", {16'h0, cnt}, 32'h0);
        chk("midrst_fv", {31'h0, fv}, 32'h0);

        stall = 0; jmp = 1; jmp_t = 32'h80;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("reboot_fv", {31'h0, fv}, 32'h0);
        @(posedge clk); #1;
        chk("reboot_ignore_pc", pc, 32'h0);
        chk("reboot_ignore_cnt", {16'h0, cnt}, 32'h0);
        idle_inputs();
        @(posedge clk); #1;
        chk("reboot_seq_pc", pc, 32'h4);
        chk("reboot_seq_cnt", {16'h0, cnt}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
